// File: rtl/card_pkg.sv
// Shared card types for the Baccarat datapath.
// Used by the dealer, 7-segment decoders and scoring.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_BLANK = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE,
    HOLD
  } dealer_state_t;

  function automatic card_t next_rank(card_t c);
    return (c == CARD_KING) ? CARD_ACE : c + 4'd1;
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/deal bundle between the game controller
// and the card dealer.
interface card_dealer_if;
  import card_pkg::*;

  logic       deal_req;
  logic       shuffle;
  card_t      card;
  logic       deal_valid;
  logic       deck_empty;
  logic [8:0] cards_left;

  modport master (
    output deal_req, shuffle,
    input  card, deal_valid, deck_empty, cards_left
  );

  modport slave (
    input  deal_req, shuffle,
    output card, deal_valid, deck_empty, cards_left
  );

endinterface

// File: rtl/card_rng.sv
// Free-running rank source cycling 1..13.
// Kept separate so it can be swapped or forced.
module card_rng
  import card_pkg::*;
(
  input  logic  clock,
  input  logic  resetb,
  output card_t rng
);

  // advance every clock regardless of dealer state
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rng <= CARD_ACE;
    else         rng <= next_rank(rng);
  end

endmodule

// File: rtl/card_dealer.sv
// Finite-shoe dealer: probes one rank per cycle from
// the rng start point until a rank with copies remains.
module card_dealer
  import card_pkg::*;
#(
  parameter int NUM_DECKS = 1
) (
  input logic          clock,
  input logic          resetb,
  card_dealer_if.slave bus
);

  localparam int CW = $clog2(4 * NUM_DECKS + 1);
  localparam logic [CW-1:0] FULL = CW'(4 * NUM_DECKS);
  localparam logic [8:0] TOTAL = 9'(52 * NUM_DECKS);

  dealer_state_t state, nxt;
  card_t         rng;
  card_t         cand;
  card_t         card_q;
  logic [CW-1:0] cnt [1:13];
  logic [8:0]    left_q;
  logic          empty_q;
  logic          hit;
  logic          fill, take, blank, load, step;

  card_rng u_rng (
    .clock  (clock),
    .resetb (resetb),
    .rng    (rng)
  );

  assign hit = (cnt[cand] != '0);

  // state register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= nxt;
  end

  // next state and datapath strobes
  always_comb begin
    nxt   = state;
    fill  = 1'b0;
    take  = 1'b0;
    blank = 1'b0;
    load  = 1'b0;
    step  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.shuffle) begin
          fill = 1'b1;
        end else if (bus.deal_req) begin
          if (left_q == '0) begin
            blank = 1'b1;
            nxt   = DONE;
          end else begin
            load = 1'b1;
            nxt  = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (hit) begin
          take = 1'b1;
          nxt  = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: nxt = bus.deal_req ? HOLD : IDLE;
      HOLD: if (!bus.deal_req) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // shoe counters, candidate rank and dealt card
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 1; i <= 13; i++) cnt[i] <= FULL;
      left_q  <= TOTAL;
      empty_q <= 1'b0;
      card_q  <= CARD_BLANK;
      cand    <= CARD_BLANK;
    end else begin
      if (fill) begin
        for (int i = 1; i <= 13; i++) cnt[i] <= FULL;
        left_q  <= TOTAL;
        empty_q <= 1'b0;
        card_q  <= CARD_BLANK;
      end
      if (blank) card_q <= CARD_BLANK;
      if (load)  cand   <= rng;
      if (step)  cand   <= next_rank(cand);
      if (take) begin
        cnt[cand] <= cnt[cand] - 1'b1;
        left_q    <= left_q - 1'b1;
        empty_q   <= (left_q == 9'd1);
        card_q    <= cand;
      end
    end
  end

  assign bus.card       = card_q;
  assign bus.deal_valid = (state == DONE);
  assign bus.deck_empty = empty_q;
  assign bus.cards_left = left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: directed table, corner
// sequences and a randomized shoe-model run.
module tb_card_dealer;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   shoe [1:13];
  int   tally [1:13];
  int   left;

  typedef struct {
    int rng;
    int card;
    int lat;
    int left;
  } vec_t;

  vec_t tbl [13];

  card_dealer_if bus();

  card_dealer #(.NUM_DECKS(1)) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge resetb) begin
    if (!resetb) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_fill();
    for (int r = 1; r <= 13; r++) shoe[r] = 4;
    left = 52;
  endfunction

  function automatic void model_deal(input int s, output int er,
                                     output int el);
    int r;
    int k;
    if (left == 0) begin
      er = 0;
      el = 1;
    end else begin
      r = s;
      k = 0;
      while (shoe[r] == 0) begin
        r = (r % 13) + 1;
        k++;
      end
      shoe[r]--;
      left--;
      tally[r]++;
      er = r;
      el = 2 + k;
    end
  endfunction

  task automatic wait_rng(input int v);
    for (int i = 0; i < 14; i++) begin
      if ((cyc % 13) + 1 == v) return;
      @(negedge clock);
    end
    chk("wait_rng", (cyc % 13) + 1, v);
  endtask

  task automatic deal(input bit hold, input bit shuf_mid,
                      output int c, output int lat);
    int s;
    int er;
    int el;
    int extra;
    s = (cyc % 13) + 1;
    model_deal(s, er, el);
    bus.deal_req = 1'b1;
    c = -1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      bus.shuffle = shuf_mid && (n == 1);
      if (bus.deal_valid) begin
        lat = n;
        c = int'(bus.card);
        break;
      end
    end
    bus.shuffle = 1'b0;
    if (lat == 0) begin
      chk("deal_timeout", 0, 1);
    end else begin
      chk("deal_card", c, er);
      chk("deal_latency", lat, el);
      chk("cards_left", int'(bus.cards_left), left);
      chk("deck_empty", int'(bus.deck_empty), int'(left == 0));
    end
    if (hold) begin
      extra = 0;
      for (int i = 0; i < 18; i++) begin
        @(negedge clock);
        if (bus.deal_valid) extra++;
      end
      chk("hold_extra_pulses", extra, 0);
      bus.deal_req = 1'b0;
      @(negedge clock);
    end else begin
      bus.deal_req = 1'b0;
      @(negedge clock);
      chk("valid_pulse_width", int'(bus.deal_valid), 0);
    end
  endtask

  initial begin
    int c;
    int l;

    tbl[0]  = '{5, 5, 2, 51};
    tbl[1]  = '{7, 7, 2, 50};
    tbl[2]  = '{7, 7, 2, 49};
    tbl[3]  = '{7, 7, 2, 48};
    tbl[4]  = '{7, 7, 2, 47};
    tbl[5]  = '{7, 8, 3, 46};
    tbl[6]  = '{13, 13, 2, 45};
    tbl[7]  = '{13, 13, 2, 44};
    tbl[8]  = '{13, 13, 2, 43};
    tbl[9]  = '{13, 13, 2, 42};
    tbl[10] = '{13, 1, 3, 41};
    tbl[11] = '{6, 6, 2, 40};
    tbl[12] = '{7, 8, 3, 39};

    bus.deal_req = 1'b0;
    bus.shuffle  = 1'b0;
    model_fill();
    for (int r = 1; r <= 13; r++) tally[r] = 0;

    repeat (3) @(negedge clock);
    resetb = 1'b1;
    @(negedge clock);
    chk("reset_card", int'(bus.card), 0);
    chk("reset_valid", int'(bus.deal_valid), 0);
    chk("reset_left", int'(bus.cards_left), 52);
    chk("reset_empty", int'(bus.deck_empty), 0);

    for (int i = 0; i < 13; i++) begin
      wait_rng(tbl[i].rng);
      deal(1'b0, 1'b0, c, l);
      chk($sformatf("tbl%0d_card", i), c, tbl[i].card);
      chk($sformatf("tbl%0d_lat", i), l, tbl[i].lat);
      chk($sformatf("tbl%0d_left", i), left, tbl[i].left);
    end

    bus.shuffle  = 1'b1;
    bus.deal_req = 1'b1;
    @(negedge clock);
    bus.shuffle = 1'b0;
    chk("shuf_deal_left", int'(bus.cards_left), 52);
    chk("shuf_deal_card", int'(bus.card), 0);
    chk("shuf_deal_valid", int'(bus.deal_valid), 0);
    model_fill();
    deal(1'b0, 1'b0, c, l);

    deal(1'b1, 1'b0, c, l);
    deal(1'b0, 1'b0, c, l);

    bus.deal_req = 1'b1;
    @(negedge clock);
    #2 resetb = 1'b0;
    #1;
    chk("async_rst_card", int'(bus.card), 0);
    chk("async_rst_valid", int'(bus.deal_valid), 0);
    chk("async_rst_left", int'(bus.cards_left), 52);
    chk("async_rst_empty", int'(bus.deck_empty), 0);
    @(negedge clock);
    bus.deal_req = 1'b0;
    @(negedge clock);
    resetb = 1'b1;
    model_fill();
    @(negedge clock);
    chk("post_rst_valid", int'(bus.deal_valid), 0);

    for (int r = 1; r <= 13; r++) tally[r] = 0;
    for (int i = 0; i < 52; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clock);
      deal($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, c, l);
    end
    for (int r = 1; r <= 13; r++)
      chk($sformatf("rank%0d_count", r), tally[r], 4);
    chk("drained_left", int'(bus.cards_left), 0);
    chk("drained_empty", int'(bus.deck_empty), 1);

    deal(1'b0, 1'b0, c, l);
    chk("empty_deal_card", c, 0);
    chk("empty_deal_lat", l, 1);
    deal(1'b1, 1'b0, c, l);

    bus.shuffle = 1'b1;
    @(negedge clock);
    bus.shuffle = 1'b0;
    model_fill();
    chk("refill_left", int'(bus.cards_left), 52);
    chk("refill_empty", int'(bus.deck_empty), 0);
    chk("refill_card", int'(bus.card), 0);

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clock);
      deal(1'b0, 1'b0, c, l);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/card_dealer.md
# card_dealer

Dealing engine for the Baccarat datapath. It models a finite shoe of NUM_DECKS standard decks: 13 ranks, each with 4×NUM_DECKS copies. On request it deals one card code, 1 = Ace … 13 = King, and never deals a rank whose copies are exhausted. Its `card` output drives the 7-segment card decoders and the score logic; code 0 (blank) means no card.

## Interface
- `NUM_DECKS`, default 1: decks in the shoe, legal range 1..8. Copies per rank = 4×NUM_DECKS.
- `clock`  in  1: single clock; all state updates on rising edge.
- `resetb`  in  1: asynchronous, active-low reset.
- `deal_req`  in  1: level request. Held high until `deal_valid` is seen.
- `shuffle`  in  1: refill the shoe to full. Sampled only in IDLE.
- `card`  out  4: last dealt card code. 0 = blank/none; 1..13 = rank.
- `deal_valid`  out  1: one-cycle pulse marking that `card` was updated by a deal.
- `deck_empty`  out  1: high while `cards_left` == 0.
- `cards_left`  out  9: cards remaining in the shoe, 0..52×NUM_DECKS.

## Operation
- Rank source:
  - Free-running counter `rng` cycles 1,2,…,13,1,… every clock, regardless of state.
  - On reset, `rng` = 1.
- Shoe state:
  - 13 per-rank counters, each ⌈log2(4×NUM_DECKS+1)⌉ bits wide.
  - On reset and on shuffle: every rank counter = 4×NUM_DECKS; `cards_left` = 52×NUM_DECKS; `card` = 0.
- States: IDLE, SEARCH, DONE, HOLD.
- IDLE:
  - `shuffle`=1: refill the shoe and stay in IDLE. Shuffle wins over a simultaneous `deal_req`; the request is serviced on a later cycle.
  - Else `deal_req`=1 and `cards_left`=0: `card` ← 0, go to DONE.
  - Else `deal_req`=1: `cand` ← `rng`, go to SEARCH.
- SEARCH, one rank probed per cycle:
  - Counter[`cand`] > 0: decrement that counter, decrement `cards_left`, `card` ← `cand`, go to DONE.
  - Counter[`cand`] = 0: `cand` ← `cand`+1, wrapping 13→1, stay in SEARCH.
  - Termination: `cards_left` > 0 guarantees a hit within 13 probes.
- DONE:
  - `deal_valid` = 1 for exactly this cycle.
  - Next state: HOLD if `deal_req`=1, else IDLE.
- HOLD: wait until `deal_req`=0, then go to IDLE. One deal is made per request assertion.
- `shuffle` outside IDLE is ignored, not queued.
- `deal_req` dropped during SEARCH: the search still completes and the deal is committed.
- Empty shoe: a deal still completes with `card`=0, `deal_valid` pulse, and `deck_empty` staying 1. No counter underflows.
- `card` holds its value between deals.
- `deck_empty` is a registered compare, updated on the same edge as `cards_left`.
- Reset asserted mid-operation: all state returns to reset values immediately, whatever the FSM state; a pending deal is lost.

## Timing
- Reset values:
  - state = IDLE
  - `card` = 0, `deal_valid` = 0
  - `deck_empty` = 0
  - `cards_left` = 52×NUM_DECKS, `rng` = 1
- Request sampled high in IDLE at edge E0:
  - Hit on first probe: SEARCH in cycle 1, DONE in cycle 2. `card` is valid from the start of cycle 2, with `deal_valid` high in cycle 2.
  - k misses before the hit: `deal_valid` in cycle 2+k, k ≤ 12, so worst case cycle 14.
  - Empty shoe: `deal_valid` in cycle 1.
- Minimum spacing between deals with a single-cycle request gap: 4 cycles (IDLE, SEARCH, DONE, IDLE).
- `cards_left` and the counters update on the edge entering DONE. Shuffle updates them on the edge after it is sampled.

## Structure
- Shared package `card_pkg`:
  - `card_t` = logic [3:0]
  - constants `CARD_BLANK`=0, `CARD_ACE`=1, `CARD_KING`=13
  - state enum `dealer_state_t` {IDLE, SEARCH, DONE, HOLD}
  - `card_pkg` is reused by the 7-segment decoder and the scoring blocks.
- Sub-module `card_rng`: the free-running 1..13 wrap counter with async active-low reset. It is separately instantiable so the bench can force it.
- The rank counters are a 13-entry register array inside `card_dealer`; no RAM.

## Test plan
- Reset → `card`=0, `deal_valid`=0, `cards_left`=52, `deck_empty`=0. Assert `deal_req` while `rng`=5 → `card`=5 and `deal_valid` in cycle 2; `cards_left`=51.
- Deal 4 cards with `rng` forced to 7 at each request → cards 7,7,7,7. A fifth request at `rng`=7 → `card`=8 after one miss (`deal_valid` in cycle 3). A sixth at `rng`=13 with the 13s exhausted → wraps and returns 1 if Aces remain.
- Deal 52 cards → each rank appears exactly 4 times, `cards_left`=0, `deck_empty`=1. A 53rd request → `card`=0, `deal_valid` in cycle 1, counters unchanged.
- `shuffle` and `deal_req` high together in IDLE → refill first (`cards_left`=52, `card`=0), then a deal follows. `shuffle` pulsed during SEARCH → ignored.
- `deal_req` held high for 20 cycles → exactly one `deal_valid` pulse. Drop and reassert → a second deal.
- `resetb` low during SEARCH → outputs return to reset values asynchronously, and the shoe is full again.
